tlu_trigger_tagger: RTL

Downstream consumer of the TLU handshake stage: timestamps every TLU trigger, captures the 16-bit trigger number shifted in from the TLU, and checks sequence continuity. Each trigger becomes one 64-bit event-tag word in a small first-word-fall-through buffer, read out with a valid/ready handshake by the readout/packet builder. Buffer overflow is counted and flagged in the data stream. The block never stalls the handshake stage.

---
 rtl/tlu_pkg.sv | 36 +++
 rtl/sync_fifo_fwft.sv | 55 +++++
 rtl/tlu_trigger_tagger.sv | 116 +++++++++++
 3 files changed

// File: rtl/tlu_pkg.sv
// Shared constants and tag-word packing for the TLU trigger tagging path.
package tlu_pkg;

    localparam int unsigned TS_WIDTH        = 32;
    localparam int unsigned TAG_WIDTH       = 64;
    localparam logic [7:0]  TAG_HEADER      = 8'hA5;

    localparam int unsigned HDR_MSB         = 63;
    localparam int unsigned HDR_LSB         = 56;
    localparam int unsigned SEQ_ERR_BIT     = 55;
    localparam int unsigned DROP_BEFORE_BIT = 54;
    localparam int unsigned TS_EST_BIT      = 53;
    localparam int unsigned CNT_MSB         = 47;
    localparam int unsigned CNT_LSB         = 32;
    localparam int unsigned TS_MSB          = 31;
    localparam int unsigned TS_LSB          = 0;

    function automatic logic [TAG_WIDTH-1:0] build_tag(
        input logic                seq_err,
        input logic                drop_before,
        input logic                ts_est,
        input logic [15:0]         trig_cnt,
        input logic [TS_WIDTH-1:0] ts
    );
        logic [TAG_WIDTH-1:0] w;
        w                  = '0;
        w[HDR_MSB:HDR_LSB] = TAG_HEADER;
        w[SEQ_ERR_BIT]     = seq_err;
        w[DROP_BEFORE_BIT] = drop_before;
        w[TS_EST_BIT]      = ts_est;
        w[CNT_MSB:CNT_LSB] = trig_cnt;
        w[TS_MSB:TS_LSB]   = ts;
        return w;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO; head word is registered storage, so writes
// reach rd_data only on the following cycle.
module sync_fifo_fwft #(
    parameter int unsigned WIDTH   = 64,
    parameter int unsigned FIFO_AW = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [WIDTH-1:0]   wr_data,
    output logic               full,
    input  logic               rd_en,
    output logic [WIDTH-1:0]   rd_data,
    output logic               empty,
    output logic [FIFO_AW:0]   level
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;
    logic             do_wr;
    logic             do_rd;

    always_comb begin
        level   = wr_ptr_q - rd_ptr_q;
        empty   = (wr_ptr_q == rd_ptr_q);
        full    = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                  (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
        do_rd   = rd_en && !empty;
        // A pop frees the slot this same edge, so a full FIFO still takes the write.
        do_wr   = wr_en && (!full || do_rd);
        wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
        rd_data = empty ? '0 : mem_q[rd_ptr_q[FIFO_AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[FIFO_AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/tlu_trigger_tagger.sv
// Timestamps TLU triggers, checks trigger-number continuity and queues one
// 64-bit tag word per trigger; never back-pressures the handshake stage.
module tlu_trigger_tagger
    import tlu_pkg::*;
#(
    parameter int unsigned FIFO_AW = 4
) (
    input  logic                 CLK,
    input  logic                 RST_SYS,
    input  logic                 TRIGGER_VALID,
    input  logic                 TRIGGER_CNT_VALID,
    input  logic [15:0]          TRIGGER_CNT,
    input  logic                 CLR_CNT,
    output logic [63:0]          TAG_DATA,
    output logic                 TAG_VALID,
    input  logic                 TAG_READY,
    output logic [FIFO_AW:0]     FIFO_LEVEL,
    output logic [15:0]          DROP_CNT,
    output logic                 OVERFLOW
);

    logic [TS_WIDTH-1:0] ts_q, ts_d;
    logic [TS_WIDTH-1:0] ts_hold_q, ts_hold_d;
    logic                trig_prev_q, trig_prev_d;
    logic                edge_seen_q, edge_seen_d;
    logic [15:0]         last_cnt_q, last_cnt_d;
    logic                armed_q, armed_d;
    logic                drop_pend_q, drop_pend_d;
    logic [15:0]         drop_cnt_q, drop_cnt_d;
    logic                overflow_q, overflow_d;

    logic                rise;
    logic                fifo_full;
    logic                fifo_empty;
    logic                pop;
    logic                push;
    logic                drop;
    logic                seq_err;
    logic                ts_est;
    logic [TS_WIDTH-1:0] word_ts;
    logic [63:0]         word;

    always_comb begin
        rise    = TRIGGER_VALID && !trig_prev_q;
        pop     = !fifo_empty && TAG_READY;
        push    = TRIGGER_CNT_VALID && (!fifo_full || pop);
        drop    = TRIGGER_CNT_VALID && fifo_full && !pop;
        seq_err = armed_q && (TRIGGER_CNT != last_cnt_q + 16'd1);
        // An edge in the pulse cycle itself holds the current count, same as ts_hold would.
        ts_est  = !rise && !edge_seen_q;
        word_ts = (edge_seen_q && !rise) ? ts_hold_q : ts_q;
        word    = build_tag(seq_err, drop_pend_q, ts_est, TRIGGER_CNT, word_ts);

        ts_d        = ts_q + TS_WIDTH'(1);
        ts_hold_d   = rise ? ts_q : ts_hold_q;
        trig_prev_d = TRIGGER_VALID;
        edge_seen_d = TRIGGER_CNT_VALID ? 1'b0 : (rise ? 1'b1 : edge_seen_q);
        last_cnt_d  = TRIGGER_CNT_VALID ? TRIGGER_CNT : last_cnt_q;
        armed_d     = armed_q || TRIGGER_CNT_VALID;
        drop_pend_d = drop ? 1'b1 : (push ? 1'b0 : drop_pend_q);
        drop_cnt_d  = (drop && drop_cnt_q != '1) ? drop_cnt_q + 16'd1 : drop_cnt_q;
        overflow_d  = overflow_q || drop;

        // Clear lands after the word above was built from pre-clear state.
        if (CLR_CNT) begin
            ts_d       = '0;
            armed_d    = 1'b0;
            drop_cnt_d = '0;
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST_SYS) begin
            ts_q        <= '0;
            ts_hold_q   <= '0;
            trig_prev_q <= 1'b0;
            edge_seen_q <= 1'b0;
            last_cnt_q  <= '0;
            armed_q     <= 1'b0;
            drop_pend_q <= 1'b0;
            drop_cnt_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            ts_q        <= ts_d;
            ts_hold_q   <= ts_hold_d;
            trig_prev_q <= trig_prev_d;
            edge_seen_q <= edge_seen_d;
            last_cnt_q  <= last_cnt_d;
            armed_q     <= armed_d;
            drop_pend_q <= drop_pend_d;
            drop_cnt_q  <= drop_cnt_d;
            overflow_q  <= overflow_d;
        end
    end

    sync_fifo_fwft #(
        .WIDTH   (64),
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk     (CLK),
        .rst     (RST_SYS),
        .wr_en   (push),
        .wr_data (word),
        .full    (fifo_full),
        .rd_en   (pop),
        .rd_data (TAG_DATA),
        .empty   (fifo_empty),
        .level   (FIFO_LEVEL)
    );

    assign TAG_VALID = !fifo_empty;
    assign DROP_CNT  = drop_cnt_q;
    assign OVERFLOW  = overflow_q;

endmodule
